// File: rtl/sprite_anim_sequencer.sv
// Frame-rate animation sequencer for one VGA sprite: frame select, flip and visibility paced by startOfFrame.
// Optional post-animation blink is built only when SPRITE_ANIM_BLINK_EN is defined.
module sprite_anim_sequencer #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_HOLD  = 5,
  parameter int BLINK_COUNT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic                          cmdValid,
  output logic                          cmdReady,
  input  logic                          cmdLoop,
  input  logic                          cmdStop,
  output logic [$clog2(NUM_FRAMES)-1:0] frameIndex,
  output logic                          flip,
  output logic                          visible,
  output logic                          busy,
  output logic                          done
);

  localparam int FI_W   = $clog2(NUM_FRAMES);
  localparam int HOLD_W = (FRAME_HOLD > 0) ? $clog2(FRAME_HOLD + 1) : 1;

  localparam logic [FI_W-1:0]   LAST_FRAME  = FI_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(FRAME_HOLD);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    BLINK,
    DONE
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                loop_mode;

`ifdef SPRITE_ANIM_BLINK_EN
  localparam int BLINK_W = (BLINK_COUNT > 0) ? $clog2(2 * BLINK_COUNT + 1) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(2 * BLINK_COUNT);
  logic [BLINK_W-1:0]  blink_cnt;
`endif

  // Stop wins over a simultaneous startOfFrame; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frameIndex <= '0;
      flip       <= 1'b0;
      visible    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmdReady   <= 1'b1;
      hold_cnt   <= HOLD_RELOAD;
      loop_mode  <= 1'b0;
`ifdef SPRITE_ANIM_BLINK_EN
      blink_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cmdStop && (state == PLAY || state == BLINK)) begin
        state      <= IDLE;
        frameIndex <= '0;
        flip       <= 1'b0;
        visible    <= 1'b1;
        busy       <= 1'b0;
        cmdReady   <= 1'b1;
        hold_cnt   <= HOLD_RELOAD;
      end else begin
        case (state)
          IDLE: begin
            if (cmdValid && cmdReady) begin
              loop_mode  <= cmdLoop;
              frameIndex <= '0;
              flip       <= 1'b0;
              visible    <= 1'b1;
              hold_cnt   <= HOLD_RELOAD;
              busy       <= 1'b1;
              cmdReady   <= 1'b0;
              state      <= PLAY;
            end
          end

          PLAY: begin
            if (startOfFrame) begin
              if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
              end else begin
                hold_cnt <= HOLD_RELOAD;
                if (frameIndex < LAST_FRAME) begin
                  frameIndex <= frameIndex + 1'b1;
                end else if (loop_mode) begin
                  frameIndex <= '0;
                  flip       <= ~flip;
                end else begin
`ifdef SPRITE_ANIM_BLINK_EN
                  blink_cnt <= BLINK_LOAD;
                  state     <= BLINK;
`else
                  done      <= 1'b1;
                  state     <= DONE;
`endif
                end
              end
            end
          end

`ifdef SPRITE_ANIM_BLINK_EN
          // The last toggle lands on an even count, so the sprite is left visible.
          BLINK: begin
            if (startOfFrame) begin
              visible <= ~visible;
              if (blink_cnt <= 1) begin
                blink_cnt <= '0;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                blink_cnt <= blink_cnt - 1'b1;
              end
            end
          end
`endif

          DONE: begin
            frameIndex <= '0;
            flip       <= 1'b0;
            visible    <= 1'b1;
            busy       <= 1'b0;
            cmdReady   <= 1'b1;
            state      <= IDLE;
          end

          default: begin
            frameIndex <= '0;
            flip       <= 1'b0;
            visible    <= 1'b1;
            busy       <= 1'b0;
            cmdReady   <= 1'b1;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed self-checking bench for sprite_anim_sequencer (NUM_FRAMES=4, FRAME_HOLD=2, BLINK_COUNT=2).
// Expectations follow SPRITE_ANIM_BLINK_EN the same way the design build does.
module tb_sprite_anim_sequencer;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       cmdValid;
  logic       cmdReady;
  logic       cmdLoop;
  logic       cmdStop;
  logic [1:0] frameIndex;
  logic       flip;
  logic       visible;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

`ifdef SPRITE_ANIM_BLINK_EN
  localparam int LAST_SOF = 16;
`else
  localparam int LAST_SOF = 12;
`endif

  sprite_anim_sequencer #(
    .NUM_FRAMES (4),
    .FRAME_HOLD (2),
    .BLINK_COUNT(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmdLoop     (cmdLoop),
    .cmdStop     (cmdStop),
    .frameIndex  (frameIndex),
    .flip        (flip),
    .visible     (visible),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step(input logic sof);
    startOfFrame = sof;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
  endtask

  task automatic sof();
    step(1'b0);
    step(1'b1);
  endtask

  task automatic accept(input logic loop_sel);
    cmdValid = 1'b1;
    cmdLoop  = loop_sel;
    step(1'b0);
    cmdValid = 1'b0;
    cmdLoop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0);
    if (frameIndex !== 2'd0) begin failures++; $display("[TB] FAIL reset_frameIndex got=%0d exp=0", frameIndex); end checks++;
    if (flip !== 1'b0) begin failures++; $display("[TB] FAIL reset_flip got=%b exp=0", flip); end checks++;
    if (visible !== 1'b1) begin failures++; $display("[TB] FAIL reset_visible got=%b exp=1", visible); end checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end checks++;
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmdReady got=%b exp=1", cmdReady); end checks++;
  endtask

  task automatic test_once();
    logic [1:0] exp_fi;
    logic       exp_vis;
    accept(1'b0);
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL once_accept_busy got=%b exp=1", busy); end checks++;
    if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL once_accept_ready got=%b exp=0", cmdReady); end checks++;
    for (int s = 1; s <= LAST_SOF; s++) begin
      sof();
      exp_fi  = (s >= 9) ? 2'd3 : 2'(s / 3);
      exp_vis = (s > 12 && (s % 2) == 1) ? 1'b0 : 1'b1;
      if (frameIndex !== exp_fi) begin failures++; $display("[TB] FAIL once_frame sof=%0d got=%0d exp=%0d", s, frameIndex, exp_fi); end checks++;
      if (visible !== exp_vis) begin failures++; $display("[TB] FAIL once_visible sof=%0d got=%b exp=%b", s, visible, exp_vis); end checks++;
      if (done !== (s == LAST_SOF)) begin failures++; $display("[TB] FAIL once_done sof=%0d got=%b exp=%b", s, done, (s == LAST_SOF)); end checks++;
    end
    step(1'b0);
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL once_done_width got=%b exp=0", done); end checks++;
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL once_ready_after got=%b exp=1", cmdReady); end checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL once_busy_after got=%b exp=0", busy); end checks++;
  endtask

  task automatic test_loop();
    logic [1:0] exp_fi;
    logic       exp_flip;
    accept(1'b1);
    for (int s = 1; s <= 24; s++) begin
      sof();
      exp_fi   = 2'((s / 3) % 4);
      exp_flip = ((s / 12) % 2) == 1;
      if (frameIndex !== exp_fi) begin failures++; $display("[TB] FAIL loop_frame sof=%0d got=%0d exp=%0d", s, frameIndex, exp_fi); end checks++;
      if (flip !== exp_flip) begin failures++; $display("[TB] FAIL loop_flip sof=%0d got=%b exp=%b", s, flip, exp_flip); end checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL loop_done sof=%0d got=%b exp=0", s, done); end checks++;
      if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL loop_ready sof=%0d got=%b exp=0", s, cmdReady); end checks++;
    end
    cmdStop = 1'b1;
    step(1'b0);
    cmdStop = 1'b0;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL loop_stop_busy got=%b exp=0", busy); end checks++;
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL loop_stop_ready got=%b exp=1", cmdReady); end checks++;
  endtask

  task automatic test_stop_sof();
    accept(1'b0);
    repeat (4) sof();
    if (frameIndex !== 2'd1) begin failures++; $display("[TB] FAIL stop_pre_frame got=%0d exp=1", frameIndex); end checks++;
    step(1'b0);
    cmdStop = 1'b1;
    step(1'b1);
    cmdStop = 1'b0;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_busy got=%b exp=0", busy); end checks++;
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL stop_ready got=%b exp=1", cmdReady); end checks++;
    if (frameIndex !== 2'd0) begin failures++; $display("[TB] FAIL stop_frame got=%0d exp=0", frameIndex); end checks++;
    if (visible !== 1'b1) begin failures++; $display("[TB] FAIL stop_visible got=%b exp=1", visible); end checks++;
    if (flip !== 1'b0) begin failures++; $display("[TB] FAIL stop_flip got=%b exp=0", flip); end checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL stop_done got=%b exp=0", done); end checks++;
    step(1'b0);
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL stop_done_late got=%b exp=0", done); end checks++;
  endtask

  task automatic test_back_to_back();
    accept(1'b0);
    sof();
    cmdValid = 1'b1;
    cmdLoop  = 1'b0;
    for (int s = 2; s <= LAST_SOF; s++) sof();
    if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done got=%b exp=1", done); end checks++;
    if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_in_done got=%b exp=0", cmdReady); end checks++;
    step(1'b0);
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle_ready got=%b exp=1", cmdReady); end checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_busy got=%b exp=0", busy); end checks++;
    step(1'b0);
    cmdValid = 1'b0;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept_busy got=%b exp=1", busy); end checks++;
    if (frameIndex !== 2'd0) begin failures++; $display("[TB] FAIL b2b_accept_frame got=%0d exp=0", frameIndex); end checks++;
    repeat (3) sof();
    if (frameIndex !== 2'd1) begin failures++; $display("[TB] FAIL b2b_restart_frame got=%0d exp=1", frameIndex); end checks++;
    cmdStop = 1'b1;
    step(1'b0);
    cmdStop = 1'b0;
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_stop_ready got=%b exp=1", cmdReady); end checks++;
  endtask

  task automatic test_reset_midway();
    accept(1'b0);
`ifdef SPRITE_ANIM_BLINK_EN
    repeat (13) sof();
    if (visible !== 1'b0) begin failures++; $display("[TB] FAIL rst_pre_visible got=%b exp=0", visible); end checks++;
`else
    repeat (10) sof();
`endif
    if (frameIndex !== 2'd3) begin failures++; $display("[TB] FAIL rst_pre_frame got=%0d exp=3", frameIndex); end checks++;
    reset = 1'b1;
    #1;
    if (visible !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_visible got=%b exp=1", visible); end checks++;
    if (frameIndex !== 2'd0) begin failures++; $display("[TB] FAIL rst_async_frame got=%0d exp=0", frameIndex); end checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_busy got=%b exp=0", busy); end checks++;
    if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_ready got=%b exp=1", cmdReady); end checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_done got=%b exp=0", done); end checks++;
    #1;
    reset = 1'b0;
    accept(1'b0);
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_new_busy got=%b exp=1", busy); end checks++;
    if (frameIndex !== 2'd0) begin failures++; $display("[TB] FAIL rst_new_frame got=%0d exp=0", frameIndex); end checks++;
    repeat (3) sof();
    if (frameIndex !== 2'd1) begin failures++; $display("[TB] FAIL rst_new_advance got=%0d exp=1", frameIndex); end checks++;
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    cmdValid     = 1'b0;
    cmdLoop      = 1'b0;
    cmdStop      = 1'b0;
    test_reset();
    test_once();
    test_loop();
    test_stop_sof();
    test_back_to_back();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
